sha256_msg_schedule: RTL and testbench

SHA256_MSG_SCHEDULE -- requirements
Module: sha256_msg_schedule

---
 rtl/sha256_msg_schedule.sv | 146 ++++++++++++++
 tb/tb_sha256_msg_schedule.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: a 16-word sliding window that emits W[0..63] under ready/valid flow control.
// Optional macro SHA256_WSCHED_WK_EN adds the K ROM and the o_wk = W[t] + K[t] output.
`timescale 1ns/1ps
module sha256_msg_schedule #(
  parameter int WIDTH  = 32,
  parameter int ROUNDS = 64
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [16*WIDTH-1:0]   i_block,
  input  logic                  i_ready,
  output logic                  o_busy,
  output logic                  o_valid,
  output logic [WIDTH-1:0]      o_w,
  output logic [WIDTH-1:0]      o_wk,
  output logic [5:0]            o_t,
  output logic                  o_last
);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_RUN = 1'b1} state_e;

  state_e      state_q, state_d;
  logic [31:0] w_q [0:15];
  logic [31:0] w_d [0:15];
  logic [5:0]  t_q, t_d;
  logic        transfer_s, last_s, load_s;
  logic [31:0] w_new_s;

  function automatic logic [31:0] add32(input logic [31:0] a, input logic [31:0] b);
    return a + b;
  endfunction

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 5'd3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 5'd10);
  endfunction

`ifdef SHA256_WSCHED_WK_EN
  localparam logic [31:0] K_ROM [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
`endif

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a start coinciding with the final transfer chains straight into the next block.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (transfer_s && last_s && !i_start) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RUN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Window and round-index next values: reload, shift-in of the next schedule word, or hold.
  always_comb begin
    transfer_s = (state_q == S_RUN) && i_ready;
    last_s     = (t_q == 6'(ROUNDS - 1));
    load_s     = i_start && ((state_q == S_IDLE) || (transfer_s && last_s));
    w_new_s    = add32(add32(sig1(w_q[14]), w_q[9]), add32(sig0(w_q[1]), w_q[0]));
    w_d        = w_q;
    t_d        = t_q;
    if (load_s) begin
      for (int k = 0; k < 16; k++) begin
        w_d[k] = i_block[16*WIDTH-1-32*k -: 32];
      end
      t_d = 6'd0;
    end else if (transfer_s) begin
      for (int k = 0; k < 15; k++) begin
        w_d[k] = w_q[k+1];
      end
      w_d[15] = w_new_s;
      if (last_s) begin
        t_d = 6'd0;
      end else begin
        t_d = t_q + 6'd1;
      end
    end else begin
      w_d = w_q;
      t_d = t_q;
    end
  end

  // Window and round-index registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < 16; k++) begin
        w_q[k] <= 32'h0;
      end
      t_q <= 6'd0;
    end else begin
      w_q <= w_d;
      t_q <= t_d;
    end
  end

  // Outputs are direct views of the state and window head.
  always_comb begin
    o_busy  = (state_q == S_RUN);
    o_valid = (state_q == S_RUN);
    o_w     = w_q[0];
    o_t     = t_q;
    o_last  = o_valid && last_s;
`ifdef SHA256_WSCHED_WK_EN
    if (o_valid) begin
      o_wk = add32(w_q[0], K_ROM[t_q]);
    end else begin
      o_wk = 32'h0;
    end
`else
    o_wk = 32'h0;
`endif
  end

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Directed bench for sha256_msg_schedule: "abc" block constants, stalls, chained blocks, mid-block reset.
`timescale 1ns/1ps
module tb_sha256_msg_schedule;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [511:0] blk;
  logic         ready;
  logic         busy, valid, last;
  logic [31:0]  w, wk;
  logic [5:0]   t;

  int checks_cnt = 0;
  int errors_cnt = 0;

  logic [31:0]  exp_w [0:63];
  logic [511:0] blk_abc;
  logic [511:0] blk_b;

  sha256_msg_schedule #(.WIDTH(32), .ROUNDS(64)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_block(blk), .i_ready(ready),
    .o_busy(busy), .o_valid(valid), .o_w(w), .o_wk(wk), .o_t(t), .o_last(last)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s obs=%08h exp=%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Reference schedule in the textbook W[t-2]/W[t-7]/W[t-15]/W[t-16] form.
  task automatic build_model(input logic [511:0] b);
    logic [31:0] s0, s1;
    for (int i = 0; i < 16; i++) exp_w[i] = b[511-32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = rotr(exp_w[i-15], 7) ^ rotr(exp_w[i-15], 18) ^ (exp_w[i-15] >> 3);
      s1 = rotr(exp_w[i-2], 17) ^ rotr(exp_w[i-2], 19) ^ (exp_w[i-2] >> 10);
      exp_w[i] = s1 + exp_w[i-7] + s0 + exp_w[i-16];
    end
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_valid"}, 32'(valid), 32'd0);
    check_eq({tag, "_busy"},  32'(busy),  32'd0);
    check_eq({tag, "_last"},  32'(last),  32'd0);
  endtask

  // Expects the first word of a freshly loaded block at the current negedge; follows it to W[63].
  task automatic run_stream(input bit stall_mode, input bit hold_start, input bit pulse_mid, input bit abc_consts);
    int idx = 0;
    int cyc = 0;
    bit r;
    while (idx < 64 && cyc < 400) begin
      check_eq($sformatf("valid[%0d]", idx), 32'(valid), 32'd1);
      check_eq($sformatf("busy[%0d]", idx),  32'(busy),  32'd1);
      check_eq($sformatf("t[%0d]", idx),     32'(t),     32'(idx));
      check_eq($sformatf("w[%0d]", idx),     w,          exp_w[idx]);
      check_eq($sformatf("last[%0d]", idx),  32'(last),  32'(idx == 63));
`ifdef SHA256_WSCHED_WK_EN
      if (abc_consts && idx == 0) check_eq("abc_wk0", wk, 32'hA3EC9318);
`else
      check_eq($sformatf("wk[%0d]", idx), wk, 32'h0);
`endif
      if (abc_consts) begin
        case (idx)
          0:  check_eq("abc_w0",  w, 32'h61626380);
          15: check_eq("abc_w15", w, 32'h00000018);
          16: check_eq("abc_w16", w, 32'h61626380);
          17: check_eq("abc_w17", w, 32'h000F0000);
          18: check_eq("abc_w18", w, 32'h7DA86405);
          default: ;
        endcase
      end
      r = !stall_mode || (cyc % 4 == 0) || (cyc % 4 == 3);
      ready = r;
      start = hold_start || (pulse_mid && idx == 10);
      @(posedge clk);
      @(negedge clk);
      if (r) idx++;
      cyc++;
    end
    check_eq("stream_done", 32'(idx), 32'd64);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    start = 1'b0;
    ready = 1'b0;
    blk   = '0;
    blk_abc = {32'h61626380, 448'h0, 32'h00000018};
    for (int k = 0; k < 16; k++) blk_b[511-32*k -: 32] = 32'h9E3779B9 * (k + 1) ^ 32'h0F0F1234;

    #12;
    check_idle("rst");
    check_eq("rst_t",  32'(t), 32'd0);
    check_eq("rst_w",  w,      32'h0);
    check_eq("rst_wk", wk,     32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("idle");

    // "abc" block, always ready.
    blk = blk_abc;
    build_model(blk_abc);
    start = 1'b1;
    ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    run_stream(1'b0, 1'b0, 1'b0, 1'b1);
    check_idle("end1");
    @(negedge clk);
    check_idle("end1b");

    // Same block with ready 1,0,0,1 and an ignored start pulse carrying a different block.
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    blk = blk_b;
    run_stream(1'b1, 1'b0, 1'b1, 1'b1);
    check_idle("end2");

    // Start held high: block B follows block A with no bubble.
    blk = blk_abc;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    blk = blk_b;
    run_stream(1'b0, 1'b1, 1'b0, 1'b1);
    build_model(blk_b);
    run_stream(1'b0, 1'b0, 1'b0, 1'b0);
    check_idle("end3");

    // Reset mid-block at t=20, then restart.
    blk = blk_abc;
    build_model(blk_abc);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    ready = 1'b1;
    n = 0;
    while (t != 6'd20 && n < 100) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    check_eq("reach_t20", 32'(t), 32'd20);
    #2 rst_n = 1'b0;
    #1;
    check_idle("arst");
    check_eq("arst_t",  32'(t), 32'd0);
    check_eq("arst_w",  w,      32'h0);
    check_eq("arst_wk", wk,     32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("post_rst");
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    run_stream(1'b0, 1'b0, 1'b0, 1'b1);
    check_idle("end4");

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
